// File: rtl/fetch_queue.sv
// Instruction-fetch stage: holds the PC, fetches from imem, and buffers
// {pc, instr} pairs in a DEPTH-entry FIFO. Decode reads the FIFO over a
// valid/ready handshake. A branch redirect reloads the PC and flushes the FIFO.
module fetch_queue #(
  parameter int unsigned   N         = 64,
  parameter int unsigned   IW        = 32,
  parameter int unsigned   DEPTH     = 4,
  parameter logic [N-1:0]  RESET_VEC = '0,
  parameter int unsigned   INC       = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     PCSrc_F,
  input  logic [N-1:0]             PCBranch_F,
  output logic [N-1:0]             imem_addr_F,
  input  logic [IW-1:0]            imem_data_F,
  output logic                     instr_valid_D,
  input  logic                     instr_ready_D,
  output logic [IW-1:0]            instr_D,
  output logic [N-1:0]             pc_D,
  output logic [$clog2(DEPTH):0]   count_F
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [N-1:0]  pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [N-1:0]  pc_mem    [DEPTH];
  logic [IW-1:0] instr_mem [DEPTH];
  logic          full;
  logic          pop;
  logic          push;

  // Handshake qualifiers; a full queue still accepts a push when the head leaves.
  always_comb begin
    full = (count == CW'(DEPTH));
    pop  = instr_valid_D & instr_ready_D;
    push = !PCSrc_F & (!full | pop);
  end

  assign imem_addr_F   = pc;
  assign instr_valid_D = (count != '0);
  assign instr_D       = instr_mem[rd_ptr];
  assign pc_D          = pc_mem[rd_ptr];
  assign count_F       = count;

  // PC, FIFO pointers, occupancy and storage; reset beats redirect beats push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_VEC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[AW'(i)]    <= '0;
        instr_mem[AW'(i)] <= '0;
      end
    end else if (PCSrc_F) begin
      // A same-cycle pop already reached decode; everything else is wrong-path.
      pc     <= PCBranch_F;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= pc;
        instr_mem[wr_ptr] <= imem_data_F;
        wr_ptr            <= wr_ptr + 1'b1;
        pc                <= pc + N'(INC);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule
